// File: rtl/jbus_arb_tracker.sv
// JBus distributed round-robin arbitration tracker for one stub agent.
// Mirrors the common owner decision so the output queue knows when it may drive.
module jbus_arb_tracker #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 16
) (
    input  logic             j_clk,
    input  logic             j_rst,
    input  logic [2:0]       j_id,
    input  logic [5:0]       j_req_in_l,
    input  logic             local_req,
    output logic [5:0]       j_req_out_l,
    output logic             local_gnt,
    output logic             bus_owner_vld,
    output logic [2:0]       bus_owner_id,
    output logic [CNT_W-1:0] grant_cnt,
    output logic             arb_err
);

    function automatic logic [2:0] mod7(input logic [3:0] v);
        return (v >= 4'd7) ? 3'(v - 4'd7) : v[2:0];
    endfunction

    logic [6:0] req_q;
    logic [6:0] req_d;
    logic       lreq_d;
    logic [2:0] last_owner;
    logic [7:0] hold_cnt;

    logic       id_ok;
    logic       req_local;
    logic       own_req;
    logic       at_lim;
    logic [2:0] start;
    logic [2:0] cand;
    logic       found;
    logic [2:0] win;
    logic       nxt_vld;
    logic [2:0] nxt_id;
    logic [2:0] nxt_last;
    logic [7:0] nxt_hold;
    logic       nxt_gnt;
    logic       new_local;

    assign id_ok     = (j_id != 3'd7);
    assign req_local = id_ok && req_q[j_id];

    // Peer bit k belongs to agent (j_id+1+k) mod 7.
    always_comb begin
        req_d = '0;
        for (int k = 0; k < 6; k++) begin
            req_d[mod7({1'b0, j_id} + 4'(k + 1))] = ~j_req_in_l[k];
        end
        if (id_ok) begin
            req_d[j_id] = local_req;
        end
    end

    always_comb begin
        own_req = bus_owner_vld && req_q[bus_owner_id];
        at_lim  = (hold_cnt == 8'(MAX_HOLD - 1));
        if (own_req) begin
            start = mod7({1'b0, bus_owner_id} + 4'd1);
        end else begin
            start = mod7({1'b0, last_owner} + 4'd1);
        end
        found = 1'b0;
        win   = 3'd0;
        cand  = 3'd0;
        // A forced rotation must skip the current owner.
        for (int i = 0; i < 7; i++) begin
            cand = mod7({1'b0, start} + 4'(i));
            if (!found && req_q[cand] &&
                !(own_req && cand == bus_owner_id)) begin
                found = 1'b1;
                win   = cand;
            end
        end

        nxt_vld  = bus_owner_vld;
        nxt_id   = bus_owner_id;
        nxt_last = last_owner;
        nxt_hold = hold_cnt;
        if (own_req && !at_lim) begin
            nxt_hold = hold_cnt + 8'd1;
        end else if (found) begin
            nxt_vld  = 1'b1;
            nxt_id   = win;
            nxt_last = win;
            nxt_hold = 8'd0;
        end else if (own_req) begin
            nxt_hold = 8'd0;
        end else begin
            nxt_vld = 1'b0;
        end

        nxt_gnt   = id_ok && nxt_vld && (nxt_id == j_id);
        new_local = nxt_gnt && !local_gnt;
    end

    always_ff @(posedge j_clk) begin
        if (j_rst) begin
            req_q         <= '0;
            lreq_d        <= 1'b0;
            last_owner    <= 3'd6;
            hold_cnt      <= 8'd0;
            j_req_out_l   <= 6'h3F;
            local_gnt     <= 1'b0;
            bus_owner_vld <= 1'b0;
            bus_owner_id  <= 3'd0;
            grant_cnt     <= '0;
            arb_err       <= 1'b0;
        end else begin
            req_q         <= req_d;
            lreq_d        <= req_local;
            last_owner    <= nxt_last;
            hold_cnt      <= nxt_hold;
            j_req_out_l   <= {6{~local_req}};
            local_gnt     <= nxt_gnt;
            bus_owner_vld <= nxt_vld;
            bus_owner_id  <= nxt_id;
            if (new_local && grant_cnt != '1) begin
                grant_cnt <= grant_cnt + CNT_W'(1);
            end
            if (!id_ok || (local_gnt && !req_local && !lreq_d)) begin
                arb_err <= 1'b1;
            end
        end
    end

endmodule
